fib_deobfuscate_decoder: RTL

//  Receive-side inverse of the encrypt/obfuscate path. Accepts one 16-bit obfuscated word.

---
 rtl/fib_obfus_pkg.sv | 45 ++++
 rtl/fib_deobfuscate_decoder_if.sv | 26 ++
 rtl/fib_serial_accum.sv | 78 +++++++
 rtl/fib_deobfuscate_decoder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/fib_obfus_pkg.sv
// Purpose: shared constants, FSM state type and keyed mix/unmix round helpers
//          for the Fibonacci obfuscation path (encrypt and decrypt sides).
// Ports:   none (package).
package fib_obfus_pkg;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned DEF_ROUNDS = 4;
  localparam int unsigned DEF_ROT    = 3;

  typedef logic [WIDTH-1:0] word_t;

  localparam word_t DEF_KEY = 16'hA5C3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNMIX  = 2'd1,
    DECODE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Rotate left by n (taken modulo WIDTH) via a doubled word.
  function automatic word_t rotl(input word_t x, input int unsigned n);
    logic [2*WIDTH-1:0] dbl;
    dbl = {x, x} << (n % WIDTH);
    return dbl[2*WIDTH-1 -: WIDTH];
  endfunction

  // Rotate right by n, expressed as the complementary left rotate.
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return rotl(x, (WIDTH - (n % WIDTH)) % WIDTH);
  endfunction

  // Forward round used by the encrypt side.
  function automatic word_t round_mix(input word_t x, input word_t key,
                                      input int unsigned r, input int unsigned rot);
    return rotl(x, rot) ^ rotl(key, r);
  endfunction

  // Exact inverse of round_mix for the same round index.
  function automatic word_t round_unmix(input word_t x, input word_t key,
                                        input int unsigned r, input int unsigned rot);
    return rotr(x ^ rotl(key, r), rot);
  endfunction

endpackage

// File: rtl/fib_deobfuscate_decoder_if.sv
// Purpose: request/response bundle between a producer of obfuscated words and
//          the decoder.
// Signals: en_decode/input_b (request), receive/done_trans/done_decode/busy
//          (status pulses/levels), out_binary (decoded result).
interface fib_deobfuscate_decoder_if;
  import fib_obfus_pkg::*;

  logic  en_decode;
  word_t input_b;
  logic  receive;
  logic  done_trans;
  logic  done_decode;
  logic  busy;
  word_t out_binary;

  modport master (
    output en_decode, input_b,
    input  receive, done_trans, done_decode, busy, out_binary
  );

  modport slave (
    input  en_decode, input_b,
    output receive, done_trans, done_decode, busy, out_binary
  );

endinterface

// File: rtl/fib_serial_accum.sv
// Purpose: serial LSB-first Fibonacci-weighted accumulator. Digit i adds
//          F(i+2) (1,2,3,5,...) when set; WIDTH digits per run.
// Ports:   clk, rst      clock, async active-high reset
//          start_i       (re)initialise acc/fa/fb/counter, begin a run
//          bit_in_i      current code digit, consumed each running cycle
//          acc_o         running sum (final once the last digit is consumed)
//          last_o        high during the cycle that consumes the final digit
module fib_serial_accum
  import fib_obfus_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  start_i,
  input  logic  bit_in_i,
  output word_t acc_o,
  output logic  last_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  word_t         acc_q, acc_d;
  word_t         fa_q,  fa_d;
  word_t         fb_q,  fb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          last_q, last_d;

  // Accumulator state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      fa_q   <= '0;
      fb_q   <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      fa_q   <= fa_d;
      fb_q   <= fb_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

  // One digit per cycle; fa/fb walk up the Fibonacci sequence.
  always_comb begin
    acc_d  = acc_q;
    fa_d   = fa_q;
    fb_d   = fb_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    last_d = last_q;
    if (start_i) begin
      acc_d  = '0;
      fa_d   = WIDTH'(1);
      fb_d   = WIDTH'(2);
      cnt_d  = '0;
      run_d  = 1'b1;
      last_d = 1'b0;
    end else if (run_q) begin
      if (bit_in_i) begin
        acc_d = acc_q + fa_q;
      end
      fa_d   = fb_q;
      fb_d   = fa_q + fb_q;
      cnt_d  = cnt_q + CW'(1);
      // Flag the digit about to be consumed next as the final one.
      last_d = (cnt_q == CW'(WIDTH - 2));
      run_d  = !last_q;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = last_q;

endmodule

// File: rtl/fib_deobfuscate_decoder.sv
// Purpose: receive-side inverse of the obfuscate path. Accepts one word,
//          undoes ROUNDS keyed rotate/XOR rounds, then converts the recovered
//          Fibonacci code (any valid representation) to binary.
// Ports:   clk, rst   clock, async active-high reset
//          dec_if     slave side of the request/response bundle:
//                     en_decode/input_b in; receive, done_trans, done_decode,
//                     busy, out_binary out (all registered)
module fib_deobfuscate_decoder
  import fib_obfus_pkg::*;
#(
  parameter int unsigned ROUNDS = DEF_ROUNDS,
  parameter int unsigned ROT    = DEF_ROT,
  parameter word_t       KEY    = DEF_KEY
) (
  input logic                      clk,
  input logic                      rst,
  fib_deobfuscate_decoder_if.slave dec_if
);

  localparam int unsigned RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  state_e        state_q, state_d;
  word_t         x_q, x_d;
  logic [RW-1:0] r_q, r_d;
  logic          receive_q, receive_d;
  logic          done_trans_q, done_trans_d;
  logic          done_decode_q, done_decode_d;
  logic          busy_q, busy_d;
  word_t         out_binary_q, out_binary_d;

  logic          start_c;
  word_t         acc;
  logic          last;

  fib_serial_accum u_accum (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_c),
    .bit_in_i (x_q[0]),
    .acc_o    (acc),
    .last_o   (last)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      x_q           <= '0;
      r_q           <= '0;
      receive_q     <= 1'b0;
      done_trans_q  <= 1'b0;
      done_decode_q <= 1'b0;
      busy_q        <= 1'b0;
      out_binary_q  <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      r_q           <= r_d;
      receive_q     <= receive_d;
      done_trans_q  <= done_trans_d;
      done_decode_q <= done_decode_d;
      busy_q        <= busy_d;
      out_binary_q  <= out_binary_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    r_d           = r_q;
    receive_d     = 1'b0;
    done_trans_d  = 1'b0;
    done_decode_d = 1'b0;
    out_binary_d  = out_binary_q;
    start_c       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dec_if.en_decode) begin
          state_d   = UNMIX;
          x_d       = dec_if.input_b;
          r_d       = RW'(ROUNDS - 1);
          receive_d = 1'b1;
        end
      end
      UNMIX: begin
        // Rounds are peeled off in reverse order of the forward mix.
        x_d = round_unmix(x_q, KEY, 32'(r_q), ROT);
        if (r_q == '0) begin
          state_d      = DECODE;
          start_c      = 1'b1;
          done_trans_d = 1'b1;
        end else begin
          r_d = r_q - RW'(1);
        end
      end
      DECODE: begin
        // The accumulator consumes x_q[0] on this edge; expose the next digit.
        x_d = x_q >> 1;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d       = IDLE;
        done_decode_d = 1'b1;
        out_binary_d  = acc;
      end
      default: state_d = IDLE;
    endcase
  end

  // Busy covers the whole operation including the done_decode pulse.
  assign busy_d = (state_d != IDLE) || done_decode_d;

  assign dec_if.receive     = receive_q;
  assign dec_if.done_trans  = done_trans_q;
  assign dec_if.done_decode = done_decode_q;
  assign dec_if.busy        = busy_q;
  assign dec_if.out_binary  = out_binary_q;

endmodule
